// File: rtl/quickq_deq_engine_pkg.sv
// rtl/quickq_deq_engine_pkg.sv - shared types and constants for the QuickQ dequeue engine
package quickQ_pkg;

    // One state per cycle: accept, head read, alternating shift write/read, count update
    typedef enum logic [2:0] {
        DQ_IDLE     = 3'd0,
        DQ_RD_HEAD  = 3'd1,
        DQ_SHIFT_WR = 3'd2,
        DQ_SHIFT_RD = 3'd3,
        DQ_UPDATE   = 3'd4
    } deqState_t;

    // Widest entry supported; modules slice the low W bits of the sentinel
    localparam int QQ_MAX_W = 64;

    // Vacated slots read as all-ones so they never win an enqueue compare
    localparam logic [QQ_MAX_W-1:0] QQ_EMPTY_SENTINEL = '1;

endpackage

// File: rtl/quickq_deq_engine.sv
// rtl/quickq_deq_engine.sv - QuickQ dequeue engine: pops head, shifts entries down, writes back N-1 (optional QQ_DEQ_CLEAR_EN)
module quickq_deq_engine
    import quickQ_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int D  = 128,
    localparam int DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          deq_req,
    output logic          deq_ready,
    output logic          deq_valid,
    output logic [W-1:0]  deq_data,
    output logic          deq_err,
    input  logic [DW-1:0] last_in,
    output logic [DW-1:0] last_out,
    output logic          last_we,
    output logic [DW-1:0] bram_addr,
    input  logic [W-1:0]  bram_rd_data,
    output logic [W-1:0]  bram_wr_data,
    output logic          bram_we
);

    localparam logic [W-1:0]  SENTINEL = QQ_EMPTY_SENTINEL[W-1:0];
    localparam logic [DW-1:0] ONE      = DW'(1);
    localparam logic [DW-1:0] TWO      = DW'(2);

    deqState_t     state_q;
    logic [DW-1:0] n_q;
    logic [DW-1:0] idx_q;
    logic          deq_ready_q;
    logic          deq_valid_q;
    logic          deq_err_q;
    logic [W-1:0]  deq_data_q;
    logic [DW-1:0] last_out_q;
    logic          last_we_q;
    logic [DW-1:0] bram_addr_q;
    logic          bram_we_q;

    // Controller: state, counters and registered outputs are all computed for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DQ_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            deq_ready_q <= 1'b1;
            deq_valid_q <= 1'b0;
            deq_err_q   <= 1'b0;
            deq_data_q  <= '0;
            last_out_q  <= '0;
            last_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_we_q   <= 1'b0;
        end else begin
            deq_valid_q <= 1'b0;
            deq_err_q   <= 1'b0;
            last_we_q   <= 1'b0;
            case (state_q)
                DQ_IDLE: begin
                    bram_addr_q <= '0;
                    bram_we_q   <= 1'b0;
                    if (deq_req) begin
                        if (last_in == '0) begin
                            deq_err_q <= 1'b1;
                        end else begin
                            n_q         <= last_in;
                            state_q     <= DQ_RD_HEAD;
                            deq_ready_q <= 1'b0;
                            // Prefetch entry 1 while the head is being captured
                            bram_addr_q <= (last_in == ONE) ? '0 : ONE;
                        end
                    end
                end
                DQ_RD_HEAD: begin
                    deq_data_q  <= bram_rd_data;
                    deq_valid_q <= 1'b1;
                    idx_q       <= '0;
                    if (n_q == ONE) begin
                        state_q    <= DQ_UPDATE;
                        last_out_q <= n_q - ONE;
                        last_we_q  <= 1'b1;
`ifdef QQ_DEQ_CLEAR_EN
                        bram_addr_q <= n_q - ONE;
                        bram_we_q   <= 1'b1;
`else
                        bram_addr_q <= '0;
                        bram_we_q   <= 1'b0;
`endif
                    end else begin
                        state_q     <= DQ_SHIFT_WR;
                        bram_addr_q <= '0;
                        bram_we_q   <= 1'b1;
                    end
                end
                DQ_SHIFT_WR: begin
                    if (idx_q == n_q - TWO) begin
                        state_q    <= DQ_UPDATE;
                        last_out_q <= n_q - ONE;
                        last_we_q  <= 1'b1;
`ifdef QQ_DEQ_CLEAR_EN
                        bram_addr_q <= n_q - ONE;
                        bram_we_q   <= 1'b1;
`else
                        bram_addr_q <= '0;
                        bram_we_q   <= 1'b0;
`endif
                    end else begin
                        state_q     <= DQ_SHIFT_RD;
                        idx_q       <= idx_q + ONE;
                        // Entry (new idx)+1 is the next one to move down
                        bram_addr_q <= idx_q + TWO;
                        bram_we_q   <= 1'b0;
                    end
                end
                DQ_SHIFT_RD: begin
                    state_q     <= DQ_SHIFT_WR;
                    bram_addr_q <= idx_q;
                    bram_we_q   <= 1'b1;
                end
                DQ_UPDATE: begin
                    state_q     <= DQ_IDLE;
                    deq_ready_q <= 1'b1;
                    bram_addr_q <= '0;
                    bram_we_q   <= 1'b0;
                end
                default: begin
                    state_q     <= DQ_IDLE;
                    deq_ready_q <= 1'b1;
                    bram_addr_q <= '0;
                    bram_we_q   <= 1'b0;
                end
            endcase
        end
    end

    // Write data is the entry read last cycle, forwarded straight back one slot lower
    always_comb begin
        bram_wr_data = '0;
        if (state_q == DQ_SHIFT_WR) begin
            bram_wr_data = bram_rd_data;
        end
`ifdef QQ_DEQ_CLEAR_EN
        else if (state_q == DQ_UPDATE) begin
            bram_wr_data = SENTINEL;
        end
`endif
    end

    assign deq_ready = deq_ready_q;
    assign deq_valid = deq_valid_q;
    assign deq_err   = deq_err_q;
    assign deq_data  = deq_data_q;
    assign last_out  = last_out_q;
    assign last_we   = last_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_we   = bram_we_q;

endmodule

// File: tb/tb_quickq_deq_engine.sv
// tb/tb_quickq_deq_engine.sv - directed self-checking bench for quickq_deq_engine with sync-read BRAM model
module tb_quickq_deq_engine;

    localparam int W   = 8;
    localparam int D   = 8;
    localparam int DW  = 3;
`ifdef QQ_DEQ_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          deq_req;
    logic          deq_ready;
    logic          deq_valid;
    logic [W-1:0]  deq_data;
    logic          deq_err;
    logic [DW-1:0] last_in;
    logic [DW-1:0] last_out;
    logic          last_we;
    logic [DW-1:0] bram_addr;
    logic [W-1:0]  bram_rd_data;
    logic [W-1:0]  bram_wr_data;
    logic          bram_we;

    logic [W-1:0]  mem [D];
    logic [W-1:0]  init_mem [D];
    logic [W-1:0]  exp_m [D];
    logic          load;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quickq_deq_engine #(.W(W), .D(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .deq_req      (deq_req),
        .deq_ready    (deq_ready),
        .deq_valid    (deq_valid),
        .deq_data     (deq_data),
        .deq_err      (deq_err),
        .last_in      (last_in),
        .last_out     (last_out),
        .last_we      (last_we),
        .bram_addr    (bram_addr),
        .bram_rd_data (bram_rd_data),
        .bram_wr_data (bram_wr_data),
        .bram_we      (bram_we)
    );

    // Single-port synchronous-read BRAM with a bench-side preload port
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < D; i++) mem[i] <= init_mem[i];
        end else if (bram_we) begin
            mem[bram_addr] <= bram_wr_data;
        end
        bram_rd_data <= mem[bram_addr];
    end

    task automatic load_mem(input logic [8*W-1:0] v);
        for (int i = 0; i < D; i++) init_mem[i] = v[8*W-1-i*W -: W];
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [8*W-1:0] v);
        for (int i = 0; i < D; i++) exp_m[i] = v[8*W-1-i*W -: W];
        for (int i = 0; i < D; i++) begin
            n_cmp++;
            if (mem[i] !== exp_m[i]) begin
                n_err++;
                $display("FAIL %s mem[%0d]: got %0h expected %0h", name, i, mem[i], exp_m[i]);
            end
        end
    endtask

    // Issues one request at cycle 0 and records per-cycle observations until ready returns
    task automatic run_deq(input logic [DW-1:0] n, input bit hold,
                           output int vld_c, output int vld_n, output int lwe_c, output int lwe_n,
                           output int rdy_c, output int nwr, output int maxa);
        vld_c = -1; vld_n = 0; lwe_c = -1; lwe_n = 0; rdy_c = -1; nwr = 0; maxa = 0;
        @(negedge clk);
        deq_req = 1'b1;
        last_in = n;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (hold) last_in = c[0] ? 3'd5 : 3'd1;
            else      deq_req = 1'b0;
            if (deq_valid) begin vld_n++; if (vld_c < 0) vld_c = c; end
            if (last_we)   begin lwe_n++; if (lwe_c < 0) lwe_c = c; end
            if (bram_we)   nwr++;
            if (int'(bram_addr) > maxa) maxa = int'(bram_addr);
            if (deq_ready) begin rdy_c = c; deq_req = 1'b0; break; end
        end
        n_cmp++;
        if (rdy_c < 0) begin
            n_err++;
            $display("FAIL run_deq timeout: ready not seen within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; deq_req = 1'b0; last_in = '0; load = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({deq_ready, deq_valid, deq_err, last_we, bram_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 10000", {deq_ready, deq_valid, deq_err, last_we, bram_we});
        end
        n_cmp++;
        if ({deq_data, last_out, bram_addr, bram_wr_data} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_data: got %0h expected 0", {deq_data, last_out, bram_addr, bram_wr_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int errs = 0, wes = 0, rdy_lo = 0;
        logic err1;
        @(negedge clk);
        deq_req = 1'b1; last_in = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            deq_req = 1'b0;
            if (c == 1) err1 = deq_err;
            if (deq_err) errs++;
            if (bram_we || last_we) wes++;
            if (!deq_ready) rdy_lo++;
        end
        n_cmp++;
        if (err1 !== 1'b1) begin n_err++; $display("FAIL empty_err_cycle1: got %b expected 1", err1); end
        n_cmp++;
        if (errs !== 1) begin n_err++; $display("FAIL empty_err_pulses: got %0d expected 1", errs); end
        n_cmp++;
        if (wes !== 0) begin n_err++; $display("FAIL empty_writes: got %0d expected 0", wes); end
        n_cmp++;
        if (rdy_lo !== 0) begin n_err++; $display("FAIL empty_ready_low: got %0d expected 0", rdy_lo); end
    endtask

    task automatic test_single();
        int vc, vn, lc, ln, rc, nw, ma;
        load_mem({8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77});
        run_deq(3'd1, 1'b0, vc, vn, lc, ln, rc, nw, ma);
        n_cmp++;
        if (vc !== 2) begin n_err++; $display("FAIL n1_valid_cycle: got %0d expected 2", vc); end
        n_cmp++;
        if (deq_data !== 8'h05) begin n_err++; $display("FAIL n1_data: got %0h expected 05", deq_data); end
        n_cmp++;
        if (lc !== 2) begin n_err++; $display("FAIL n1_last_we_cycle: got %0d expected 2", lc); end
        n_cmp++;
        if (last_out !== 3'd0) begin n_err++; $display("FAIL n1_last_out: got %0d expected 0", last_out); end
        n_cmp++;
        if (rc !== 3) begin n_err++; $display("FAIL n1_ready_cycle: got %0d expected 3", rc); end
        n_cmp++;
        if (nw !== CLR) begin n_err++; $display("FAIL n1_writes: got %0d expected %0d", nw, CLR); end
        check_mem("n1", {(CLR != 0) ? 8'hFF : 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77});
    endtask

    task automatic test_n4();
        int vc, vn, lc, ln, rc, nw, ma;
        load_mem({8'h03, 8'h07, 8'h09, 8'h0C, 8'hA4, 8'hA5, 8'hA6, 8'hA7});
        run_deq(3'd4, 1'b0, vc, vn, lc, ln, rc, nw, ma);
        n_cmp++;
        if (vc !== 2) begin n_err++; $display("FAIL n4_valid_cycle: got %0d expected 2", vc); end
        n_cmp++;
        if (deq_data !== 8'h03) begin n_err++; $display("FAIL n4_data: got %0h expected 03", deq_data); end
        n_cmp++;
        if (lc !== 7) begin n_err++; $display("FAIL n4_last_we_cycle: got %0d expected 7", lc); end
        n_cmp++;
        if (last_out !== 3'd3) begin n_err++; $display("FAIL n4_last_out: got %0d expected 3", last_out); end
        n_cmp++;
        if (rc !== 8) begin n_err++; $display("FAIL n4_ready_cycle: got %0d expected 8", rc); end
        n_cmp++;
        if (nw !== 3 + CLR) begin n_err++; $display("FAIL n4_writes: got %0d expected %0d", nw, 3 + CLR); end
        check_mem("n4", {8'h07, 8'h09, 8'h0C, (CLR != 0) ? 8'hFF : 8'h0C, 8'hA4, 8'hA5, 8'hA6, 8'hA7});
    endtask

    task automatic test_full();
        int vc, vn, lc, ln, rc, nw, ma;
        load_mem({8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
        run_deq(3'd7, 1'b0, vc, vn, lc, ln, rc, nw, ma);
        n_cmp++;
        if (deq_data !== 8'h00) begin n_err++; $display("FAIL full_data: got %0h expected 00", deq_data); end
        n_cmp++;
        if (last_out !== 3'd6) begin n_err++; $display("FAIL full_last_out: got %0d expected 6", last_out); end
        n_cmp++;
        if (rc !== 14) begin n_err++; $display("FAIL full_ready_cycle: got %0d expected 14", rc); end
        n_cmp++;
        if (nw !== 6 + CLR) begin n_err++; $display("FAIL full_writes: got %0d expected %0d", nw, 6 + CLR); end
        n_cmp++;
        if (ma > 6) begin n_err++; $display("FAIL full_max_addr: got %0d expected <= 6", ma); end
        check_mem("full", {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, (CLR != 0) ? 8'hFF : 8'h06, 8'h07});
    endtask

    task automatic test_back_to_back();
        int vc, vn, lc, ln, rc, nw, ma;
        load_mem({8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0B, 8'h0D, 8'h0E});
        run_deq(3'd3, 1'b1, vc, vn, lc, ln, rc, nw, ma);
        repeat (2) begin
            @(negedge clk);
            if (deq_valid) vn++;
            if (last_we) ln++;
        end
        n_cmp++;
        if (vn !== 1) begin n_err++; $display("FAIL held_valid_pulses: got %0d expected 1", vn); end
        n_cmp++;
        if (ln !== 1) begin n_err++; $display("FAIL held_last_we_pulses: got %0d expected 1", ln); end
        n_cmp++;
        if (deq_data !== 8'h02) begin n_err++; $display("FAIL held_data: got %0h expected 02", deq_data); end
        n_cmp++;
        if (last_out !== 3'd2) begin n_err++; $display("FAIL held_last_out: got %0d expected 2", last_out); end
        n_cmp++;
        if (rc !== 6) begin n_err++; $display("FAIL held_ready_cycle: got %0d expected 6", rc); end
        check_mem("held", {8'h04, 8'h06, (CLR != 0) ? 8'hFF : 8'h06, 8'h08, 8'h0A, 8'h0B, 8'h0D, 8'h0E});
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        load_mem({8'h03, 8'h07, 8'h09, 8'h0C, 8'hA4, 8'hA5, 8'hA6, 8'hA7});
        @(negedge clk);
        deq_req = 1'b1; last_in = 3'd4;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            deq_req = 1'b0;
            if (bram_we) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL rstmid_shift_wr: got no write expected write within 10 cycles"); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({deq_ready, deq_valid, deq_err, last_we, bram_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL rstmid_ctrl: got %b expected 10000", {deq_ready, deq_valid, deq_err, last_we, bram_we});
        end
        n_cmp++;
        if ({deq_data, last_out, bram_addr, bram_wr_data} !== 22'd0) begin
            n_err++;
            $display("FAIL rstmid_data: got %0h expected 0", {deq_data, last_out, bram_addr, bram_wr_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_n4();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
